// File: rtl/tile_rom_burst_server.sv
// rtl/tile_rom_burst_server.sv - sprite tile ROM burst responder; optional timeout/fill via TILE_ROM_TIMEOUT_EN
module tile_rom_burst_server #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
`ifdef TILE_ROM_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 1024
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_rd,
  input  logic [31:0] io_addr,
  input  logic [7:0]  io_burstLength,
  output logic        io_wait_n,
  output logic        io_valid,
  output logic [63:0] io_dout,
  output logic        io_burstDone,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_burstLength,
  input  logic        mem_waitReq,
  input  logic        mem_valid,
  input  logic [63:0] mem_dout
`ifdef TILE_ROM_TIMEOUT_EN
  ,
  output logic        io_error
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DATA
`ifdef TILE_ROM_TIMEOUT_EN
    ,
    FILL
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [8:0]  remaining_q, remaining_d;
  logic        io_valid_q, io_valid_d;
  logic [63:0] io_dout_q, io_dout_d;
  logic        burst_done_q, burst_done_d;

`ifdef TILE_ROM_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              error_q, error_d;
  assign io_error = error_q;
`endif

  // The client may only hand over a request while nothing is in flight.
  assign io_wait_n       = (state_q == IDLE) & ~reset;
  assign mem_rd          = (state_q == REQ);
  assign mem_addr        = addr_q;
  assign mem_burstLength = len_q;
  assign io_valid        = io_valid_q;
  assign io_dout         = io_dout_q;
  assign io_burstDone    = burst_done_q;

  // State register and all datapath flops; reset drops any partial burst.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      remaining_q  <= '0;
      io_valid_q   <= 1'b0;
      io_dout_q    <= '0;
      burst_done_q <= 1'b0;
`ifdef TILE_ROM_TIMEOUT_EN
      idle_cnt_q   <= '0;
      error_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      remaining_q  <= remaining_d;
      io_valid_q   <= io_valid_d;
      io_dout_q    <= io_dout_d;
      burst_done_q <= burst_done_d;
`ifdef TILE_ROM_TIMEOUT_EN
      idle_cnt_q   <= idle_cnt_d;
      error_q      <= error_d;
`endif
    end
  end

  // Next-state logic: latch the request, hold mem_rd until accepted, forward beats.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    remaining_d  = remaining_q;
    io_valid_d   = 1'b0;
    io_dout_d    = io_dout_q;
    burst_done_d = 1'b0;
`ifdef TILE_ROM_TIMEOUT_EN
    idle_cnt_d   = idle_cnt_q;
    error_d      = error_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (io_rd && io_wait_n) begin
          // Region offset wraps silently; memory is addressed in whole 64-bit words.
          addr_d      = (io_addr + BASE_ADDR) & 32'hFFFF_FFF8;
          len_d       = io_burstLength;
          remaining_d = (io_burstLength == 8'd0) ? 9'd256 : {1'b0, io_burstLength};
          state_d     = REQ;
        end
      end
      REQ: begin
`ifdef TILE_ROM_TIMEOUT_EN
        idle_cnt_d = '0;
`endif
        if (!mem_waitReq) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (mem_valid) begin
          io_valid_d  = 1'b1;
          io_dout_d   = mem_dout;
          remaining_d = remaining_q - 9'd1;
`ifdef TILE_ROM_TIMEOUT_EN
          idle_cnt_d  = '0;
`endif
          if (remaining_q == 9'd1) begin
            burst_done_d = 1'b1;
            state_d      = IDLE;
          end
        end
`ifdef TILE_ROM_TIMEOUT_EN
        else if (idle_cnt_q == IDLE_W'(TIMEOUT - 1)) begin
          // Memory went quiet: pad the burst out so the client still sees N beats.
          error_d = 1'b1;
          state_d = FILL;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
`endif
      end
`ifdef TILE_ROM_TIMEOUT_EN
      FILL: begin
        io_valid_d  = 1'b1;
        io_dout_d   = '0;
        remaining_d = remaining_q - 9'd1;
        if (remaining_q == 9'd1) begin
          burst_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tile_rom_burst_server.sv
// tb/tb_tile_rom_burst_server.sv - randomized scoreboard bench for tile_rom_burst_server
module tb_tile_rom_burst_server;

  localparam logic [31:0] BASE = 32'h0100_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_rd = 1'b0;
  logic [31:0] io_addr = '0;
  logic [7:0]  io_burstLength = '0;
  logic        io_wait_n;
  logic        io_valid;
  logic [63:0] io_dout;
  logic        io_burstDone;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [7:0]  mem_burstLength;
  logic        mem_waitReq = 1'b0;
  logic        mem_valid = 1'b0;
  logic [63:0] mem_dout = '0;

  tile_rom_burst_server #(.BASE_ADDR(BASE)) dut (
    .clock(clock),
    .reset(reset),
    .io_rd(io_rd),
    .io_addr(io_addr),
    .io_burstLength(io_burstLength),
    .io_wait_n(io_wait_n),
    .io_valid(io_valid),
    .io_dout(io_dout),
    .io_burstDone(io_burstDone),
    .mem_rd(mem_rd),
    .mem_addr(mem_addr),
    .mem_burstLength(mem_burstLength),
    .mem_waitReq(mem_waitReq),
    .mem_valid(mem_valid),
    .mem_dout(mem_dout)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    int          beats;
    bit          stop4;
  } req_t;

  typedef struct {
    logic [63:0] data;
    bit          last;
    int          cyc;
  } beat_t;

  req_t  exp_req[$];
  beat_t exp_beat[$];
  int    checks = 0;
  int    passes = 0;
  int    cyc = 0;
  int    io_seen = 0;
  int    exp_total = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Output monitor: every io beat must match the next word the memory model returned.
  always @(negedge clock) begin
    beat_t b;
    if (!reset) begin
      if (io_valid) begin
        io_seen++;
        if (exp_beat.size() == 0) begin
          chk("stray_io_beat", 64'(exp_beat.size()), 64'd1);
        end else begin
          b = exp_beat.pop_front();
          chk("beat_data", io_dout, b.data);
          chk("beat_latency", 64'(cyc), 64'(b.cyc));
          chk("burst_done", 64'(io_burstDone), 64'(b.last));
          if (io_burstDone) chk("wait_n_at_done", 64'(io_wait_n), 64'd1);
        end
      end else begin
        if (io_burstDone) chk("done_without_valid", 64'(io_burstDone), 64'd0);
        if (exp_beat.size() != 0 && exp_beat[0].cyc <= cyc) begin
          chk("missing_beat", 64'(io_valid), 64'd1);
          void'(exp_beat.pop_front());
        end
      end
    end
  end

  // Memory model: random stalls, random gaps, stray valids outside a burst.
  initial begin
    bit          busy;
    bit          parked;
    bit          pending;
    logic [31:0] held_addr;
    int          left;
    req_t        r;
    busy = 0; parked = 0; pending = 0; left = 0; held_addr = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        busy = 0; parked = 0; pending = 0;
        mem_valid = 1'b0;
        mem_waitReq = 1'b0;
      end else if (busy) begin
        chk("mem_rd_in_data", 64'(mem_rd), 64'd0);
        chk("wait_n_in_data", 64'(io_wait_n), 64'd0);
        mem_waitReq = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 2) != 0) begin
          mem_valid = 1'b1;
          mem_dout = {$urandom, $urandom};
          left--;
          exp_beat.push_back('{data: mem_dout, last: (!r.stop4 && left == 0), cyc: cyc + 1});
          if (left == 0) begin
            busy = 0;
            parked = r.stop4;
          end
        end else begin
          mem_valid = 1'b0;
        end
      end else if (parked) begin
        mem_valid = 1'b0;
      end else begin
        mem_valid = ($urandom_range(0, 3) == 0);
        mem_dout = {$urandom, $urandom};
        if (pending) begin
          chk("mem_rd_held", 64'(mem_rd), 64'd1);
          chk("mem_addr_held", mem_addr, held_addr);
        end
        if (mem_rd) begin
          chk("wait_n_in_req", 64'(io_wait_n), 64'd0);
          mem_waitReq = ($urandom_range(0, 1) == 0);
          if (!mem_waitReq) begin
            pending = 0;
            if (exp_req.size() == 0) begin
              chk("unexpected_mem_req", 64'(mem_rd), 64'd0);
            end else begin
              r = exp_req.pop_front();
              chk("mem_addr", mem_addr, r.addr);
              chk("mem_burst_len", 64'(mem_burstLength), 64'(r.len));
              left = r.stop4 ? 4 : r.beats;
              busy = 1;
            end
          end else begin
            pending = 1;
            held_addr = mem_addr;
          end
        end else begin
          pending = 0;
          mem_waitReq = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // Present one request and hold it until the responder takes it.
  task automatic issue(input logic [31:0] a, input logic [7:0] l, input bit stop4);
    int   n;
    req_t r;
    n = 0;
    io_rd = 1'b1;
    io_addr = a;
    io_burstLength = l;
    while (!io_wait_n && n < 3000) begin
      @(negedge clock);
      n++;
    end
    if (!io_wait_n) begin
      chk("accept_timeout", 64'(io_wait_n), 64'd1);
      io_rd = 1'b0;
    end else begin
      r.addr  = (a + BASE) & 32'hFFFF_FFF8;
      r.len   = l;
      r.beats = (l == 8'd0) ? 256 : int'(l);
      r.stop4 = stop4;
      exp_req.push_back(r);
      exp_total += stop4 ? 4 : r.beats;
      @(negedge clock);
      io_rd = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!(exp_req.size() == 0 && exp_beat.size() == 0 && io_wait_n) && n < 5000) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk("drain", 64'(exp_req.size() + exp_beat.size()), 64'd0);
  endtask

  initial begin
    int s;
    int n;
    logic [7:0] l;
    repeat (3) @(negedge clock);
    chk("reset_wait_n", 64'(io_wait_n), 64'd0);
    chk("reset_valid", 64'(io_valid), 64'd0);
    chk("reset_done", 64'(io_burstDone), 64'd0);
    chk("reset_mem_rd", 64'(mem_rd), 64'd0);
    chk("reset_dout", io_dout, 64'd0);
    reset = 1'b0;
    #1;
    chk("wait_n_after_reset", 64'(io_wait_n), 64'd1);
    @(negedge clock);

    issue(32'h0000_0100, 8'd16, 0);
    issue(32'h0000_0207, 8'd32, 0);
    issue(32'h0000_0000, 8'd0, 0);
    issue(32'hFFFF_FFF3, 8'd1, 0);
    for (int i = 0; i < 25; i++) begin
      l = ($urandom_range(0, 11) == 0) ? 8'd0 : 8'($urandom_range(1, 40));
      issue($urandom, l, 0);
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end
    drain();

    s = io_seen;
    issue(32'h0000_0040, 8'd16, 1);
    n = 0;
    while (io_seen < s + 4 && n < 500) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk("partial_beats", 64'(io_seen - s), 64'd4);
    reset = 1'b1;
    @(negedge clock);
    #1;
    chk("wait_n_in_reset", 64'(io_wait_n), 64'd0);
    reset = 1'b0;
    #1;
    chk("post_reset_valid", 64'(io_valid), 64'd0);
    chk("post_reset_done", 64'(io_burstDone), 64'd0);
    chk("post_reset_wait_n", 64'(io_wait_n), 64'd1);
    @(negedge clock);
    issue(32'h0000_0080, 8'd8, 0);
    drain();
    repeat (5) @(negedge clock);
    chk("total_beats", 64'(io_seen), 64'(exp_total));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
